mem_stage_ctrl: RTL

- MEM-stage data-memory sequencer for the pipelined LC-3b core, directly downstream of forwarding_unit.
- Consumes forward_MEM_data_sel and forward_MEM_addr_sel, runs the D-cache handshake for LDB/LDW/LDI/STB/STW/STI, and stalls the pipeline while an access is outstanding.
- Captures the in-flight WB writeback during a stall and drives the forward_save bundle (save_load_regfile/save_dest/save_data) back to the forwarding unit.

---
 rtl/mem_stage_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage D-cache sequencer for LC-3b loads/stores
// Runs the cache handshake, stalls the pipe, and holds the in-flight WB value as forward_save.
module mem_stage_ctrl #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_valid,
    input  logic [3:0]        mem_opcode,
    input  logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_src_data,
    input  logic              fwd_data_sel,
    input  logic              fwd_addr_sel,
    input  logic              wb_load_regfile,
    input  logic [2:0]        wb_dest,
    input  logic [WORD_W-1:0] wb_data,
    input  logic [WORD_W-1:0] dmem_rdata,
    input  logic              dmem_resp,
    output logic [WORD_W-1:0] dmem_address,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [1:0]        dmem_byte_enable,
    output logic [WORD_W-1:0] dmem_wdata,
    output logic              stall_mem,
    output logic [WORD_W-1:0] mem_result,
    output logic              save_load_regfile,
    output logic [2:0]        save_dest,
    output logic [WORD_W-1:0] save_data
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] sdata_q, sdata_d;
    logic [WORD_W-1:0] result_q, result_d;
    logic [3:0]        op_q, op_d;
    logic              save_load_q, save_load_d;
    logic [2:0]        save_dest_q, save_dest_d;
    logic [WORD_W-1:0] save_data_q, save_data_d;

    logic              in_mem_op;
    logic              in_indirect;
    logic              op_load;
    logic              op_byte;
    logic [WORD_W-1:0] word_addr;
    logic [7:0]        load_byte;

    // opcode[1] marks the memory group, opcode[0] a store, opcode[3:2] byte/word/indirect.
    assign in_mem_op   = mem_valid && mem_opcode[1] && (mem_opcode[3:2] != 2'b11);
    assign in_indirect = mem_opcode[3];
    assign op_load     = ~op_q[0];
    assign op_byte     = (op_q[3:2] == 2'b00);
    assign word_addr   = {addr_q[WORD_W-1:1], 1'b0};
    assign load_byte   = addr_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        sdata_d          = sdata_q;
        result_d         = result_q;
        op_d             = op_q;
        save_load_d      = save_load_q;
        save_dest_d      = save_dest_q;
        save_data_d      = save_data_q;
        dmem_address     = '0;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_byte_enable = 2'b00;
        dmem_wdata       = '0;
        stall_mem        = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_mem_op) begin
                    stall_mem   = 1'b1;
                    addr_d      = (in_indirect && fwd_addr_sel) ? wb_data : mem_addr;
                    sdata_d     = fwd_data_sel ? wb_data : mem_src_data;
                    op_d        = mem_opcode;
                    state_d     = in_indirect ? PTR : DATA;
                    save_load_d = wb_load_regfile;
                    if (wb_load_regfile) begin
                        save_dest_d = wb_dest;
                        save_data_d = wb_data;
                    end
                end
            end
            PTR: begin
                stall_mem    = 1'b1;
                dmem_read    = 1'b1;
                dmem_address = word_addr;
                if (dmem_resp) begin
                    addr_d  = {dmem_rdata[WORD_W-1:1], 1'b0};
                    state_d = DATA;
                end
            end
            DATA: begin
                stall_mem    = 1'b1;
                dmem_address = op_byte ? addr_q : word_addr;
                if (op_load) begin
                    dmem_read = 1'b1;
                end else begin
                    dmem_write = 1'b1;
                    if (op_byte) begin
                        dmem_wdata       = {sdata_q[7:0], sdata_q[7:0]};
                        dmem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
                    end else begin
                        dmem_wdata       = sdata_q;
                        dmem_byte_enable = 2'b11;
                    end
                end
                if (dmem_resp) begin
                    if (op_load) begin
                        result_d = op_byte ? {{(WORD_W-8){load_byte[7]}}, load_byte} : dmem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                // Pipeline latches mem_result this cycle; forward_save is no longer needed.
                save_load_d = 1'b0;
                save_dest_d = '0;
                save_data_d = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            sdata_q     <= '0;
            result_q    <= '0;
            op_q        <= '0;
            save_load_q <= 1'b0;
            save_dest_q <= '0;
            save_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sdata_q     <= sdata_d;
            result_q    <= result_d;
            op_q        <= op_d;
            save_load_q <= save_load_d;
            save_dest_q <= save_dest_d;
            save_data_q <= save_data_d;
        end
    end

    assign mem_result        = result_q;
    assign save_load_regfile = save_load_q;
    assign save_dest         = save_dest_q;
    assign save_data         = save_data_q;
endmodule
